id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Parametrised instruction-decode stage for the in-order RISC-V pipeline; sits between IF and EX.
- Integrates the register file, immediate generation and load-use/branch hazard detection.
- Resolves all six conditional branches plus JAL in ID, with MEM→ID operand forwarding.
- Owns the registered ID/EX pipeline boundary, uses valid/ready handshakes on both sides, and keeps a stall-cycle performance counter.

Parameters:
XLEN, 64, register/data width (32 or 64)
NUM_REGS, 32, architectural registers (x0 hardwired zero)
PC_W, 32, program-counter width
CNT_W, 32, stall-counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
if_valid_i  in  1  IF presents instruction
if_ready_o  out  1  ID accepts instruction this cycle
instr_i  in  32  instruction word
pc_i  in  PC_W  instruction PC
flush_i  in  1  kill ID contents and ID/EX register (later-stage redirect)
ex_ready_i  in  1  EX can take ID/EX contents
ex_rd_i, mem_rd_i  in  5  destination registers in EX / MEM
ex_reg_write_i, mem_reg_write_i  in  1  EX / MEM instruction writes rd
ex_mem_read_i, mem_mem_read_i  in  1  EX / MEM instruction is a load
mem_alu_data_i  in  XLEN  MEM-stage ALU result for forwarding
wb_en_i  in  1  writeback enable
wb_rd_i  in  5  writeback destination
wb_data_i  in  XLEN  writeback data
id_valid_o  out  1  ID/EX register holds a valid instruction
rs1_data_o, rs2_data_o, imm_o  out  XLEN  registered operands / sign-extended immediate
pc_o  out  PC_W  registered PC
rd_o  out  5; funct3_o  out  3; opcode_o  out  7  registered fields
redirect_o  out  1  branch/JAL taken (combinational, accept cycle only)
redirect_pc_o  out  PC_W  pc_i + imm, truncated to PC_W
stall_cnt_o  out  CNT_W  count of stall cycles

Behaviour:
- Reset (rst_ni=0 at a clock edge): all registered outputs 0, id_valid_o=0, stall_cnt_o=0, all registers cleared. Reset mid-stall or mid-handshake discards everything.
- Register file: 2R1W; write on clock edge when wb_en_i and wb_rd_i≠0. Reads of x0 return 0. Same-cycle read of wb_rd_i returns wb_data_i (write-first bypass).
- Load-use stall:
  - Condition: ex_mem_read_i, ex_rd_i≠0, and ex_rd_i matches any used source (rs1 for all but LUI/AUIPC/JAL; rs2 for R/S/B types).
- Branch stall (B-type only):
  - ex_reg_write_i with ex_rd_i≠0 matching a source; or
  - mem_mem_read_i with mem_rd_i≠0 matching a source.
- Branch forwarding: mem_reg_write_i and not mem_mem_read_i, mem_rd_i≠0 matching → compare uses mem_alu_data_i. Forwarding affects the compare only; registered operands still come from the file.
- stall = if_valid_i & (load-use | branch stall).
- if_ready_o = ex_ready_i & ~stall & ~flush_i.
- Accept = if_valid_i & if_ready_o.
- ID/EX register, in priority order:
  - flush_i: id_valid_o←0.
  - else ex_ready_i & stall: insert bubble, id_valid_o←0, other fields don't-care.
  - else ex_ready_i: load decoded fields, id_valid_o←accept.
  - else: hold all outputs.
- Branch compare on XLEN operands: BEQ/BNE equality; BLT/BGE signed; BLTU/BGEU unsigned. JAL is always taken. JALR is not resolved here.
- redirect_o asserted only in an accept cycle. Zero when stalled, when ex_ready_i=0, or when flush_i=1 (flush_i wins).
- stall_cnt_o increments each cycle stall=1 and ex_ready_i=1; wraps modulo 2^CNT_W.
- Immediates per I/S/B/U/J formats, sign-extended to XLEN.
- Latency: 1 cycle from accept to id_valid_o.

Test Plan:
- Reset then write x5=0x1234 via WB; present ADD x1,x5,x0 the same cycle → next cycle id_valid_o=1, rs1_data_o=0x1234 (bypass).
- EX holds LD x3 (ex_mem_read_i=1, ex_rd_i=3); present ADD x4,x3,x3 → if_ready_o=0, one bubble (id_valid_o=0), stall_cnt_o=1. Deassert load → ADD accepted.
- BLT with x1=-1, x2=1 at pc 0x100, imm 0x20 → redirect_o=1, redirect_pc_o=0x120. BLTU with the same values → redirect_o=0.
- BEQ x6,x7 with MEM ALU writing x6=5 and x7=5 in file → forwarded, redirect_o=1. Same case with MEM a load → one stall cycle, no redirect.
- ex_ready_i=0 for 3 cycles with valid instruction → outputs held, if_ready_o=0, stall_cnt_o unchanged.
- flush_i coincident with a taken branch accept → redirect_o=0, id_valid_o=0 next cycle.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, immediate generation, hazard detection,
// in-ID branch/JAL resolution and the registered ID/EX boundary with a stall counter.
module id_stage #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             flush_i,
    input  logic             ex_ready_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             ex_reg_write_i,
    input  logic             mem_reg_write_i,
    input  logic             ex_mem_read_i,
    input  logic             mem_mem_read_i,
    input  logic [XLEN-1:0]  mem_alu_data_i,
    input  logic             wb_en_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             id_valid_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [4:0]       rd_o,
    output logic [2:0]       funct3_o,
    output logic [6:0]       opcode_o,
    output logic             redirect_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1b;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_REG32  = 7'h3b;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] rs1_rf, rs2_rf;
    logic            uses_rs1, uses_rs2, is_branch, is_jal;
    logic            load_use, branch_stall, stall, accept;
    logic            fwd_a, fwd_b, taken;
    logic [XLEN-1:0] op_a, op_b;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en_i && wb_rd_i != 5'd0) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    // Write-first: a same-cycle writeback is visible to the read ports.
    assign rs1_rf = (rs1 == 5'd0) ? '0 :
                    (wb_en_i && wb_rd_i == rs1) ? wb_data_i : regs[rs1];
    assign rs2_rf = (rs2 == 5'd0) ? '0 :
                    (wb_en_i && wb_rd_i == rs2) ? wb_data_i : regs[rs2];

    assign uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2  = (opcode == OP_REG || opcode == OP_REG32 ||
                        opcode == OP_STORE || opcode == OP_BRANCH);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);

    assign load_use = ex_mem_read_i && ex_rd_i != 5'd0 &&
                      ((uses_rs1 && ex_rd_i == rs1) || (uses_rs2 && ex_rd_i == rs2));

    // A branch compares in ID, so any EX result or MEM load it depends on is not yet usable.
    assign branch_stall = is_branch &&
        ((ex_reg_write_i && ex_rd_i != 5'd0 && (ex_rd_i == rs1 || ex_rd_i == rs2)) ||
         (mem_mem_read_i && mem_rd_i != 5'd0 && (mem_rd_i == rs1 || mem_rd_i == rs2)));

    assign stall = if_valid_i && (load_use || branch_stall);

    // Handshake: an instruction transfers from IF on a cycle where if_valid_i and
    // if_ready_o are both high; ID/EX advances only on cycles where ex_ready_i is high.
    assign if_ready_o = ex_ready_i && !stall && !flush_i;
    assign accept     = if_valid_i && if_ready_o;

    assign fwd_a = mem_reg_write_i && !mem_mem_read_i && mem_rd_i != 5'd0 && mem_rd_i == rs1;
    assign fwd_b = mem_reg_write_i && !mem_mem_read_i && mem_rd_i != 5'd0 && mem_rd_i == rs2;
    assign op_a  = fwd_a ? mem_alu_data_i : rs1_rf;
    assign op_b  = fwd_b ? mem_alu_data_i : rs2_rf;

    always_comb begin
        imm32 = 32'd0;
        case (opcode)
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_i[31:12], 12'd0};
            OP_JAL:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (op_a == op_b);
            3'b001:  taken = (op_a != op_b);
            3'b100:  taken = ($signed(op_a) <  $signed(op_b));
            3'b101:  taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  taken = (op_a <  op_b);
            3'b111:  taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    assign redirect_o    = accept && (is_jal || (is_branch && taken));
    assign redirect_pc_o = pc_i + imm[PC_W-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                  stall_cnt_o <= '0;
        else if (stall && ex_ready_i) stall_cnt_o <= stall_cnt_o + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_valid_o <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            pc_o       <= '0;
            rd_o       <= '0;
            funct3_o   <= '0;
            opcode_o   <= '0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (ex_ready_i && stall) begin
            id_valid_o <= 1'b0;
        end else if (ex_ready_i) begin
            id_valid_o <= accept;
            rs1_data_o <= rs1_rf;
            rs2_data_o <= rs2_rf;
            imm_o      <= imm;
            pc_o       <= pc_i;
            rd_o       <= rd;
            funct3_o   <= funct3;
            opcode_o   <= opcode;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the decode stage.
module tb_id_stage;

    localparam int XLEN  = 64;
    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid, if_ready, flush, ex_ready;
    logic [31:0]      instr;
    logic [PC_W-1:0]  pc;
    logic [4:0]       ex_rd, mem_rd, wb_rd;
    logic             ex_reg_write, mem_reg_write, ex_mem_read, mem_mem_read, wb_en;
    logic [XLEN-1:0]  mem_alu_data, wb_data;
    logic             id_valid, redirect;
    logic [XLEN-1:0]  rs1_data, rs2_data, imm_out;
    logic [PC_W-1:0]  pc_out, redirect_pc;
    logic [4:0]       rd_out;
    logic [2:0]       funct3_out;
    logic [6:0]       opcode_out;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN), .NUM_REGS(32), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .ex_ready_i(ex_ready),
        .ex_rd_i(ex_rd), .mem_rd_i(mem_rd), .ex_reg_write_i(ex_reg_write),
        .mem_reg_write_i(mem_reg_write), .ex_mem_read_i(ex_mem_read),
        .mem_mem_read_i(mem_mem_read), .mem_alu_data_i(mem_alu_data),
        .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .id_valid_o(id_valid), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .imm_o(imm_out), .pc_o(pc_out), .rd_o(rd_out), .funct3_o(funct3_out),
        .opcode_o(opcode_out), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
        .stall_cnt_o(stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [63:0]     m_regs [32];
    logic            m_valid;
    logic [63:0]     m_rs1, m_rs2, m_imm;
    logic [PC_W-1:0] m_pc;
    logic [4:0]      m_rd;
    logic [2:0]      m_f3;
    logic [6:0]      m_op;
    logic [CNT_W-1:0] m_cnt;
    logic [PC_W-1:0] exp_q[$];
    logic            last_ready, last_redirect;
    logic [PC_W-1:0] last_rpc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h1b, 7'h73: return sx(longint'(ins[31:20]), 12);
            7'h23: return sx(longint'({ins[31:25], ins[11:7]}), 12);
            7'h63: return sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
            7'h37, 7'h17: return sx(longint'(ins[31:12]), 20) * 4096;
            7'h6f: return sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [2:0] f3,
                                          input logic [6:0] f7);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [11:0] im);
        return {im, r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] r1, input logic [4:0] r2,
                                          input logic [2:0] f3, input logic [11:0] im);
        return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] r1, input logic [4:0] r2,
                                          input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] im);
        return {im, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    task automatic idle();
        rst_n = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        instr = 32'h0000_0013; pc = '0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_reg_write = 1'b0; mem_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_mem_read = 1'b0; wb_en = 1'b0; mem_alu_data = '0; wb_data = '0;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        logic [6:0]  op;
        logic [4:0]  a1, a2;
        logic        u1, u2, is_b, is_jal, lu, bs, stl, rdy, acc, tk, loaded;
        logic [63:0] va, vb, im, ra, rb;
        #1;
        op = instr[6:0]; a1 = instr[19:15]; a2 = instr[24:20];
        is_b   = (op == 7'h63);
        is_jal = (op == 7'h6f);
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        u2 = (op == 7'h33 || op == 7'h3b || op == 7'h23 || op == 7'h63);
        lu = ex_mem_read && ex_rd != 0 && ((u1 && ex_rd == a1) || (u2 && ex_rd == a2));
        bs = is_b && ((ex_reg_write && ex_rd != 0 && (ex_rd == a1 || ex_rd == a2)) ||
                      (mem_mem_read && mem_rd != 0 && (mem_rd == a1 || mem_rd == a2)));
        stl = if_valid && (lu || bs);
        rdy = ex_ready && !stl && !flush;
        acc = if_valid && rdy;
        ra = model_read(a1); rb = model_read(a2);
        va = (mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == a1) ? mem_alu_data : ra;
        vb = (mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == a2) ? mem_alu_data : rb;
        case (instr[14:12])
            3'd0: tk = (va == vb);
            3'd1: tk = (va != vb);
            3'd4: tk = ($signed(va) < $signed(vb));
            3'd5: tk = ($signed(va) >= $signed(vb));
            3'd6: tk = (va < vb);
            3'd7: tk = (va >= vb);
            default: tk = 1'b0;
        endcase
        im = model_imm(instr);
        last_ready = if_ready; last_redirect = redirect; last_rpc = redirect_pc;
        if (rst_n) begin
            check("if_ready", 64'(if_ready), 64'(rdy));
            check("redirect", 64'(redirect), 64'(acc && (is_jal || (is_b && tk))));
            if (acc && (is_jal || (is_b && tk)))
                check("redirect_pc", 64'(redirect_pc), 64'(PC_W'(pc + im[PC_W-1:0])));
        end
        loaded = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 64'd0;
            m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
            m_rd = 0; m_f3 = 0; m_op = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            if (stl && ex_ready) m_cnt = m_cnt + 1;
            if (flush) m_valid = 0;
            else if (ex_ready && stl) m_valid = 0;
            else if (ex_ready) begin
                m_valid = acc; m_rs1 = ra; m_rs2 = rb; m_imm = im; m_pc = pc;
                m_rd = instr[11:7]; m_f3 = instr[14:12]; m_op = op;
                if (acc) begin exp_q.push_back(pc); loaded = 1'b1; end
            end
            if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        end
        #1;
        check("id_valid", 64'(id_valid), 64'(m_valid));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (m_valid) begin
            check("rs1_data", rs1_data, m_rs1);
            check("rs2_data", rs2_data, m_rs2);
            check("imm", imm_out, m_imm);
            check("rd", 64'(rd_out), 64'(m_rd));
            check("funct3", 64'(funct3_out), 64'(m_f3));
            check("opcode", 64'(opcode_out), 64'(m_op));
        end
        if (loaded && exp_q.size() > 0) check("sb_pc", 64'(pc_out), 64'(exp_q.pop_front()));
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'(signed'(-$urandom_range(1, 3)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        rd = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7)); f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0: return enc_r(rd, r1, r2, f3, $urandom_range(0, 1) ? 7'h20 : 7'h00);
            1: return enc_i(7'h13, rd, r1, f3, 12'($urandom));
            2: return enc_i(7'h03, rd, r1, f3, 12'($urandom));
            3: return enc_s(r1, r2, f3, 12'($urandom));
            4: return enc_b(r1, r2, f3, {12'($urandom), 1'b0});
            5: return enc_u(7'h37, rd, 20'($urandom));
            6: return enc_u(7'h17, rd, 20'($urandom));
            7: return enc_j(rd, {20'($urandom), 1'b0});
            default: return enc_i(7'h67, rd, r1, 3'd0, 12'($urandom));
        endcase
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        step(); step();
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);

        // Writeback bypass into a same-cycle read
        idle();
        wb_en = 1; wb_rd = 5; wb_data = 64'h1234;
        if_valid = 1; instr = enc_r(5'd1, 5'd5, 5'd0, 3'd0, 7'd0); pc = 32'h10;
        step();
        check("bypass_valid", 64'(id_valid), 64'd1);
        check("bypass_rs1", rs1_data, 64'h1234);

        // Load-use stall, then release
        idle();
        ex_mem_read = 1; ex_rd = 3;
        if_valid = 1; instr = enc_r(5'd4, 5'd3, 5'd3, 3'd0, 7'd0); pc = 32'h14;
        step();
        check("lu_ready", 64'(last_ready), 64'd0);
        check("lu_bubble", 64'(id_valid), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        ex_mem_read = 0;
        step();
        check("lu_accept", 64'(id_valid), 64'd1);

        // Signed vs unsigned compare
        idle(); wb_en = 1; wb_rd = 1; wb_data = '1; step();
        idle(); wb_en = 1; wb_rd = 2; wb_data = 64'd1; step();
        idle(); if_valid = 1; pc = 32'h100; instr = enc_b(5'd1, 5'd2, 3'd4, 13'h20);
        step();
        check("blt_redirect", 64'(last_redirect), 64'd1);
        check("blt_target", 64'(last_rpc), 64'h120);
        instr = enc_b(5'd1, 5'd2, 3'd6, 13'h20);
        step();
        check("bltu_redirect", 64'(last_redirect), 64'd0);

        // MEM forwarding into the compare, then MEM load forces a stall
        idle(); wb_en = 1; wb_rd = 7; wb_data = 64'd5; step();
        idle(); if_valid = 1; pc = 32'h200; instr = enc_b(5'd6, 5'd7, 3'd0, 13'h40);
        mem_reg_write = 1; mem_rd = 6; mem_alu_data = 64'd5;
        step();
        check("fwd_redirect", 64'(last_redirect), 64'd1);
        mem_mem_read = 1;
        step();
        check("memld_redirect", 64'(last_redirect), 64'd0);
        check("memld_ready", 64'(last_ready), 64'd0);
        check("memld_bubble", 64'(id_valid), 64'd0);

        // EX back-pressure holds everything
        idle(); if_valid = 1; pc = 32'h300; instr = enc_i(7'h13, 5'd9, 5'd5, 3'd0, 12'hfff);
        step();
        ex_ready = 0; pc = 32'h304; instr = enc_r(5'd8, 5'd1, 5'd2, 3'd0, 7'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_ready", 64'(last_ready), 64'd0);
            check("hold_pc", 64'(pc_out), 64'h300);
        end

        // Flush beats a taken JAL
        idle(); if_valid = 1; flush = 1; pc = 32'h400; instr = enc_j(5'd1, 21'h80);
        step();
        check("flush_redirect", 64'(last_redirect), 64'd0);
        check("flush_valid", 64'(id_valid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n         = ($urandom_range(0, 79) != 0);
            if_valid      = ($urandom_range(0, 4) != 0);
            flush         = ($urandom_range(0, 9) == 0);
            ex_ready      = ($urandom_range(0, 4) != 0);
            instr         = rand_instr();
            pc            = $urandom & 32'hffff_fffc;
            ex_rd         = 5'($urandom_range(0, 7));
            mem_rd        = 5'($urandom_range(0, 7));
            ex_reg_write  = 1'($urandom);
            mem_reg_write = 1'($urandom);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            mem_mem_read  = ($urandom_range(0, 3) == 0);
            mem_alu_data  = rand_val();
            wb_en         = 1'($urandom);
            wb_rd         = 5'($urandom_range(0, 31));
            wb_data       = rand_val();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
